axi_rd_slave_sram: RTL and testbench

- AXI4 read-channel responder (AR + R) in front of a single-port synchronous SRAM.
- Serves FIXED and INCR bursts from the core-side read master, or from a test harness.
- Returns one beat per handshake, with RID echo, RRESP and RLAST generation.
- Sits on the memory side of the read master, one instance per SRAM-backed read target.

---
 rtl/axi_rd_slave_sram.sv | 205 ++++++++++++++++++++
 tb/tb_axi_rd_slave_sram.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_slave_sram.sv
// AXI4 read-channel (AR + R) responder in front of a single-port synchronous SRAM.
// Optional DECERR/SLVERR generation is enabled by defining AXI_RD_SLAVE_ERR_CHECK_EN.
module axi_rd_slave_sram #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned MEM_AW = 12,
  parameter logic [ADDR_W-1:0] BASE = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  input  logic [ID_W-1:0]   s_ar_id,
  input  logic [ADDR_W-1:0] s_ar_addr,
  input  logic [LEN_W-1:0]  s_ar_len,
  input  logic [2:0]        s_ar_size,
  input  logic [1:0]        s_ar_burst,
  output logic              s_r_valid,
  input  logic              s_r_ready,
  output logic [ID_W-1:0]   s_r_id,
  output logic [DATA_W-1:0] s_r_data,
  output logic [1:0]        s_r_resp,
  output logic              s_r_last,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BSH   = $clog2(BYTES);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [1:0] {IDLE, FETCH, CAPT, RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic                r_valid_q, r_valid_d;
  logic [ID_W-1:0]     r_id_q, r_id_d;
  logic [DATA_W-1:0]   r_data_q, r_data_d;
  logic [1:0]          r_resp_q, r_resp_d;
  logic                r_last_q, r_last_d;
  logic                mem_en_q, mem_en_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;

  logic                ar_hs_c;
  logic [ADDR_W-1:0]   step_c;
  logic [ADDR_W-1:0]   addr_nxt_c;
  logic [1:0]          ar_resp_c;
  logic [1:0]          nxt_resp_c;
  logic [1:0]          cur_resp_c;

  // Byte address to SRAM word index; out-of-range addresses alias by truncation.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return MEM_AW'(off >> BSH);
  endfunction

  assign s_ar_ready = (state_q == IDLE) && !reset;
  assign ar_hs_c    = s_ar_valid && s_ar_ready;

  // Beat-to-beat address: FIXED repeats, everything else steps as INCR.
  assign step_c     = ADDR_W'(1) << size_q;
  assign addr_nxt_c = (burst_q == BURST_FIXED) ? addr_q
                                               : ((addr_q & ~(step_c - ADDR_W'(1))) + step_c);

`ifdef AXI_RD_SLAVE_ERR_CHECK_EN
  logic slverr_q, slverr_d;
  logic ar_slverr_c;

  function automatic logic [1:0] resp_of(input logic [ADDR_W-1:0] a, input logic slv);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    if ((a < BASE) || ((off >> (BSH + MEM_AW)) != '0)) return 2'b11;
    if (slv) return 2'b10;
    return 2'b00;
  endfunction

  assign ar_slverr_c = (s_ar_size > 3'(BSH)) || s_ar_burst[1];
  assign slverr_d    = ar_hs_c ? ar_slverr_c : slverr_q;
  assign ar_resp_c   = resp_of(s_ar_addr, ar_slverr_c);
  assign nxt_resp_c  = resp_of(addr_nxt_c, slverr_q);
  assign cur_resp_c  = resp_of(addr_q, slverr_q);

  always_ff @(posedge clk) begin
    if (reset) slverr_q <= 1'b0;
    else       slverr_q <= slverr_d;
  end
`else
  assign ar_resp_c  = RESP_OKAY;
  assign nxt_resp_c = RESP_OKAY;
  assign cur_resp_c = RESP_OKAY;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    r_valid_d  = r_valid_q;
    r_id_d     = r_id_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;

    unique case (state_q)
      IDLE: begin
        if (ar_hs_c) begin
          id_d       = s_ar_id;
          addr_d     = s_ar_addr;
          len_d      = s_ar_len;
          size_d     = s_ar_size;
          burst_d    = s_ar_burst;
          beat_d     = '0;
          mem_en_d   = (ar_resp_c == RESP_OKAY);
          mem_addr_d = word_addr(s_ar_addr);
          state_d    = FETCH;
        end
      end
      FETCH: state_d = CAPT;
      CAPT: begin
        r_data_d  = (cur_resp_c != RESP_OKAY) ? '0 : mem_rdata;
        r_resp_d  = cur_resp_c;
        r_id_d    = id_q;
        r_last_d  = (beat_q == len_q);
        r_valid_d = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (s_r_ready) begin
          r_valid_d = 1'b0;
          r_last_d  = 1'b0;
          if (r_last_q) begin
            state_d = IDLE;
          end else begin
            beat_d     = beat_q + LEN_W'(1);
            addr_d     = addr_nxt_c;
            mem_en_d   = (nxt_resp_c == RESP_OKAY);
            mem_addr_d = word_addr(addr_nxt_c);
            state_d    = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      r_valid_q  <= r_valid_d;
      r_id_q     <= r_id_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      r_last_q   <= r_last_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign s_r_valid = r_valid_q;
  assign s_r_id    = r_id_q;
  assign s_r_data  = r_data_q;
  assign s_r_resp  = r_resp_q;
  assign s_r_last  = r_last_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_axi_rd_slave_sram.sv
// Directed self-checking bench for axi_rd_slave_sram with a behavioural 1-cycle SRAM.
module tb_axi_rd_slave_sram;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned MEM_AW = 12;

  localparam logic [63:0] W0    = 64'hC0DE_0000_0000_0000;
  localparam logic [63:0] W1    = 64'hC0DE_0000_0000_0001;
  localparam logic [63:0] W2    = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W3    = 64'hC0DE_0000_0000_0003;
  localparam logic [63:0] W4095 = 64'hC0DE_0000_0000_0FFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_ar_valid;
  logic              s_ar_ready;
  logic [ID_W-1:0]   s_ar_id;
  logic [ADDR_W-1:0] s_ar_addr;
  logic [LEN_W-1:0]  s_ar_len;
  logic [2:0]        s_ar_size;
  logic [1:0]        s_ar_burst;
  logic              s_r_valid;
  logic              s_r_ready;
  logic [ID_W-1:0]   s_r_id;
  logic [DATA_W-1:0] s_r_data;
  logic [1:0]        s_r_resp;
  logic              s_r_last;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_slave_sram dut (
    .clk        (clk),
    .reset      (reset),
    .s_ar_valid (s_ar_valid),
    .s_ar_ready (s_ar_ready),
    .s_ar_id    (s_ar_id),
    .s_ar_addr  (s_ar_addr),
    .s_ar_len   (s_ar_len),
    .s_ar_size  (s_ar_size),
    .s_ar_burst (s_ar_burst),
    .s_r_valid  (s_r_valid),
    .s_r_ready  (s_r_ready),
    .s_r_id     (s_r_id),
    .s_r_data   (s_r_data),
    .s_r_resp   (s_r_resp),
    .s_r_last   (s_r_last),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one AR and return 1 time unit after the accepting edge.
  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    s_ar_valid = 1'b1;
    s_ar_id    = id;
    s_ar_addr  = addr;
    s_ar_len   = len;
    s_ar_size  = size;
    s_ar_burst = burst;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (s_ar_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    s_ar_valid = 1'b0;
    if (!done) check("ar_timeout", 64'd0, 64'd1);
  endtask

  // Wait for one R beat, check it, optionally stall it, then complete the handshake.
  task automatic get_beat(input string tag, input logic [63:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id, input int stall);
    int  w    = 0;
    bit  seen = 0;
    if (stall > 0) s_r_ready = 1'b0;
    while (w < 20 && !seen) begin
      @(negedge clk);
      w++;
      if (s_r_valid) seen = 1;
    end
    if (!seen) begin
      check({tag, ".timeout"}, 64'd0, 64'd1);
      s_r_ready = 1'b1;
      return;
    end
    check({tag, ".lat"},  64'(w), 64'd3);
    check({tag, ".data"}, s_r_data, d);
    check({tag, ".rlid"}, {58'd0, s_r_resp, s_r_last, s_r_id}, {58'd0, resp, last, id});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {s_r_data}, d);
      check({tag, ".hold_ctl"}, {56'd0, s_r_valid, mem_en, s_r_resp, s_r_last, s_r_id},
            {56'd0, 1'b1, 1'b0, resp, last, id});
    end
    s_r_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = W0 | 64'(i);
    mem[2]     = W2;
    mem_rdata  = '0;
    reset      = 1'b1;
    s_ar_valid = 1'b0;
    s_ar_id    = '0;
    s_ar_addr  = '0;
    s_ar_len   = '0;
    s_ar_size  = '0;
    s_ar_burst = '0;
    s_r_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst.ar_ready", {63'd0, s_ar_ready}, 64'd0);
    check("rst.r_valid",  {63'd0, s_r_valid}, 64'd0);
    check("rst.r_data",   s_r_data, 64'd0);
    check("rst.ctl",      {56'd0, s_r_resp, s_r_last, s_r_id, mem_en}, 64'd0);
    reset = 1'b0;
    #1;
    check("rst.ar_ready_rel", {63'd0, s_ar_ready}, 64'd1);

    // single beat
    do_ar(4'd5, 64'h8000_0010, 8'd0, 3'd3, 2'b01);
    get_beat("single", W2, 2'b00, 1'b1, 4'd5, 0);
    check("single.ar_ready", {63'd0, s_ar_ready}, 64'd1);

    // INCR burst of 4
    do_ar(4'd3, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    get_beat("incr.b1", W0, 2'b00, 1'b0, 4'd3, 0);
    get_beat("incr.b2", W1, 2'b00, 1'b0, 4'd3, 0);
    check("incr.ar_busy", {63'd0, s_ar_ready}, 64'd0);
    get_beat("incr.b3", W2, 2'b00, 1'b0, 4'd3, 0);
    get_beat("incr.b4", W3, 2'b00, 1'b1, 4'd3, 0);
    check("incr.ar_ready", {63'd0, s_ar_ready}, 64'd1);

    // backpressure on beat 2
    do_ar(4'd7, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    get_beat("bp.b1", W0, 2'b00, 1'b0, 4'd7, 0);
    get_beat("bp.b2", W1, 2'b00, 1'b0, 4'd7, 5);
    get_beat("bp.b3", W2, 2'b00, 1'b0, 4'd7, 0);
    get_beat("bp.b4", W3, 2'b00, 1'b1, 4'd7, 0);

    // FIXED repeats word 1
    do_ar(4'd2, 64'h8000_0008, 8'd2, 3'd3, 2'b00);
    get_beat("fixed.b1", W1, 2'b00, 1'b0, 4'd2, 0);
    get_beat("fixed.b2", W1, 2'b00, 1'b0, 4'd2, 0);
    get_beat("fixed.b3", W1, 2'b00, 1'b1, 4'd2, 0);

    // sub-word INCR: 0x8000_0004 then 0x8000_0008
    do_ar(4'd1, 64'h8000_0004, 8'd1, 3'd2, 2'b01);
    get_beat("sub.b1", W0, 2'b00, 1'b0, 4'd1, 0);
    get_beat("sub.b2", W1, 2'b00, 1'b1, 4'd1, 0);

`ifdef AXI_RD_SLAVE_ERR_CHECK_EN
    do_ar(4'd4, 64'h7FFF_FFF8, 8'd1, 3'd3, 2'b01);
    get_beat("dec.b1", 64'd0, 2'b11, 1'b0, 4'd4, 0);
    get_beat("dec.b2", W0,    2'b00, 1'b1, 4'd4, 0);
    do_ar(4'd6, 64'h8000_0000, 8'd1, 3'd4, 2'b01);
    get_beat("size.b1", 64'd0, 2'b10, 1'b0, 4'd6, 0);
    get_beat("size.b2", 64'd0, 2'b10, 1'b1, 4'd6, 0);
    do_ar(4'd8, 64'h8000_0000, 8'd1, 3'd3, 2'b10);
    get_beat("wrap.b1", 64'd0, 2'b10, 1'b0, 4'd8, 0);
    get_beat("wrap.b2", 64'd0, 2'b10, 1'b1, 4'd8, 0);
`else
    do_ar(4'd4, 64'h7FFF_FFF8, 8'd1, 3'd3, 2'b01);
    get_beat("dec.b1", W4095, 2'b00, 1'b0, 4'd4, 0);
    get_beat("dec.b2", W0,    2'b00, 1'b1, 4'd4, 0);
    do_ar(4'd6, 64'h8000_0000, 8'd1, 3'd4, 2'b01);
    get_beat("size.b1", W0, 2'b00, 1'b0, 4'd6, 0);
    get_beat("size.b2", W2, 2'b00, 1'b1, 4'd6, 0);
    do_ar(4'd8, 64'h8000_0000, 8'd1, 3'd3, 2'b10);
    get_beat("wrap.b1", W0, 2'b00, 1'b0, 4'd8, 0);
    get_beat("wrap.b2", W1, 2'b00, 1'b1, 4'd8, 0);
`endif

    // reset while beat 2 of a 4-beat burst is waiting in RESP
    do_ar(4'd10, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
    get_beat("rmb.b1", W0, 2'b00, 1'b0, 4'd10, 0);
    s_r_ready = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (s_r_valid) seen = 1;
      end
      check("rmb.b2_seen", {63'd0, seen}, 64'd1);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rmb.rst", {61'd0, s_r_valid, s_ar_ready, mem_en}, 64'd0);
    @(negedge clk);
    reset     = 1'b0;
    s_r_ready = 1'b1;
    #1;
    check("rmb.ar_ready", {63'd0, s_ar_ready}, 64'd1);
    begin
      logic any_v = 1'b0;
      repeat (5) begin
        @(negedge clk);
        any_v = any_v | s_r_valid | mem_en;
      end
      check("rmb.silent", {63'd0, any_v}, 64'd0);
    end
    do_ar(4'd9, 64'h8000_0018, 8'd0, 3'd3, 2'b01);
    get_beat("rmb.new", W3, 2'b00, 1'b1, 4'd9, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
